md5_msg_padder: RTL

- Upstream feeder for md5_chunk_cruncher.
- Accepts a byte stream for one message and assembles each 512-bit chunk in a 64-byte buffer. Appends MD5 padding: 0x80, zero fill, then the 64-bit little-endian bit length.
- Serves chunk words to the cruncher's gaddr/mdata read port and sequences cruncher start/done per chunk.
- Signals completion once the final chunk has been crunched and the cruncher digest is valid.

---
 rtl/md5_pkg.sv | 31 +++
 rtl/md5_chunk_buffer.sv | 35 +++
 rtl/md5_msg_padder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 message padder.
// Holds the chunk geometry, the padding constants, the FSM state encoding
// and a helper that picks one byte out of the appended bit length.
package md5_pkg;

  localparam int CHUNK_BYTES = 64;
  localparam int LEN_W       = 64;
  localparam int CNT_W       = LEN_W - 3;   // byte count; bit length = count << 3

  localparam logic [7:0] PAD_BYTE   = 8'h80;
  localparam logic [5:0] LEN_OFFSET = 6'd56;
  localparam logic [5:0] LAST_PTR   = 6'(CHUNK_BYTES - 1);

  typedef logic [2:0] state_t;

  localparam state_t FILL  = 3'd0;
  localparam state_t PAD   = 3'd1;
  localparam state_t LEN   = 3'd2;
  localparam state_t START = 3'd3;
  localparam state_t WAIT  = 3'd4;
  localparam state_t DONE  = 3'd5;

  // Byte idx (0 = least significant) of the 64-bit message bit length.
  function automatic logic [7:0] len_byte(input logic [CNT_W-1:0] cnt,
                                          input logic [2:0]       idx);
    logic [LEN_W-1:0] bits;
    bits = {cnt, 3'b000};
    return bits[8*idx +: 8];
  endfunction

endpackage

// File: rtl/md5_chunk_buffer.sv
// 64-byte chunk buffer.
// Ports:
//   clk   - clock
//   we    - byte write enable
//   waddr - byte address of the write
//   wdata - byte to write
//   raddr - word index of the read
//   rdata - little-endian word: byte 4*raddr in [7:0], byte 4*raddr+3 in [31:24]
// The read is combinational so the cruncher sees data in the same cycle it
// presents an address.
module md5_chunk_buffer (
  input  logic        clk,
  input  logic        we,
  input  logic [5:0]  waddr,
  input  logic [7:0]  wdata,
  input  logic [3:0]  raddr,
  output logic [31:0] rdata
);

  logic [7:0] mem [0:63];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign rdata[8*gi +: 8] = mem[{raddr, LANE}];
    end
  endgenerate

endmodule

// File: rtl/md5_msg_padder.sv
// MD5 message padder: feeds one padded message, chunk by chunk, to the
// MD5 chunk cruncher.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   in_data/in_valid/in_last/in_ready - byte stream of one message
//   gaddr, mdata  - cruncher word read port (combinational)
//   crunch_start  - one-cycle start pulse per chunk
//   crunch_done   - cruncher done level (high when idle)
//   msg_done      - high once the final chunk has been crunched, until reset
module md5_msg_padder
  import md5_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic [3:0]  gaddr,
  output logic [31:0] mdata,
  output logic        crunch_start,
  input  logic        crunch_done,
  output logic        msg_done
);

  state_t           state_reg, state_next;
  state_t           ret_reg, ret_next;
  logic [5:0]       byte_ptr_reg, byte_ptr_next;
  logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic             pad_pending_reg, pad_pending_next;

  logic       buf_we;
  logic [7:0] buf_wdata;

  assign in_ready     = (state_reg == FILL) && !reset;
  assign crunch_start = (state_reg == START);
  assign msg_done     = (state_reg == DONE);

  always_comb begin
    state_next       = state_reg;
    ret_next         = ret_reg;
    byte_ptr_next    = byte_ptr_reg;
    byte_cnt_next    = byte_cnt_reg;
    pad_pending_next = pad_pending_reg;
    buf_we           = 1'b0;
    buf_wdata        = in_data;

    case (state_reg)
      FILL: begin
        if (in_valid) begin
          buf_we        = 1'b1;
          byte_ptr_next = byte_ptr_reg + 6'd1;
          byte_cnt_next = byte_cnt_reg + 1'b1;
          if (in_last) begin
            pad_pending_next = 1'b1;
            if (byte_ptr_reg == LAST_PTR) begin
              state_next = START;
              ret_next   = PAD;
            end else begin
              state_next = PAD;
            end
          end else if (byte_ptr_reg == LAST_PTR) begin
            state_next = START;
            ret_next   = FILL;
          end
        end
      end

      PAD: begin
        // The length goes in only once the 0x80 marker is down and we have
        // reached its slot; a marker landing at or past 56 pushes the length
        // into a further, zero-filled chunk.
        if (byte_ptr_reg == LEN_OFFSET && !pad_pending_reg) begin
          state_next = LEN;
        end else begin
          buf_we           = 1'b1;
          buf_wdata        = pad_pending_reg ? PAD_BYTE : 8'h00;
          pad_pending_next = 1'b0;
          byte_ptr_next    = byte_ptr_reg + 6'd1;
          if (byte_ptr_reg == LAST_PTR) begin
            state_next = START;
            ret_next   = PAD;
          end
        end
      end

      LEN: begin
        buf_we        = 1'b1;
        buf_wdata     = len_byte(byte_cnt_reg, byte_ptr_reg[2:0]);
        byte_ptr_next = byte_ptr_reg + 6'd1;
        if (byte_ptr_reg == LAST_PTR) begin
          state_next = START;
          ret_next   = DONE;
        end
      end

      // crunch_done is still high from idle here, so it is not looked at.
      START: state_next = WAIT;

      WAIT: begin
        if (crunch_done) begin
          state_next    = ret_reg;
          byte_ptr_next = 6'd0;
        end
      end

      DONE: state_next = DONE;

      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FILL;
      ret_reg         <= FILL;
      byte_ptr_reg    <= 6'd0;
      byte_cnt_reg    <= '0;
      pad_pending_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_reg         <= ret_next;
      byte_ptr_reg    <= byte_ptr_next;
      byte_cnt_reg    <= byte_cnt_next;
      pad_pending_reg <= pad_pending_next;
    end
  end

  md5_chunk_buffer u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (byte_ptr_reg),
    .wdata (buf_wdata),
    .raddr (gaddr),
    .rdata (mdata)
  );

endmodule
